// File: rtl/tbu_param.sv
// Viterbi traceback unit: walks survivor decisions backwards, emits decoded bits.
// Optional TBU_BEST_START_EN: restart from the ACS best-metric state (start_state port).
module tbu_param #(
    parameter int K      = 4,
    parameter int TB_LEN = 16,
    localparam int M     = K - 1,
    localparam int NS    = 1 << M,
    localparam int CW    = $clog2(TB_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          selection,
    input  logic [NS-1:0] d_in_0,
    input  logic [NS-1:0] d_in_1,
`ifdef TBU_BEST_START_EN
    input  logic [M-1:0]  start_state,
`endif
    output logic          d_o,
    output logic          wr_en,
    output logic          frame_done,
    output logic [CW-1:0] bit_cnt
);

    localparam logic [CW-1:0] LAST = CW'(TB_LEN - 1);

    logic [M-1:0]  pstate_q, pstate_d;
    logic          sel_q;
    logic          d_o_q, d_o_d;
    logic          wr_en_q, wr_en_d;
    logic          fd_q, fd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [M-1:0]  rs;
    logic          surv;
    logic          reload;
    logic          run;

    // Next-state, output and frame-counter logic for one traceback step
    always_comb begin
`ifdef TBU_BEST_START_EN
        rs = start_state;
`else
        rs = '0;
`endif
        surv     = selection ? d_in_1[pstate_q] : d_in_0[pstate_q];
        reload   = !enable || (sel_q && !selection);
        run      = enable && selection;
        pstate_d = reload ? rs : {surv, pstate_q[M-1:1]};
        wr_en_d  = run;
        d_o_d    = run ? d_in_1[pstate_q] : 1'b0;
        cnt_d    = cnt_q;
        fd_d     = 1'b0;
        if (reload) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, selection history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pstate_q <= '0;
            sel_q    <= 1'b0;
            d_o_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            fd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pstate_q <= pstate_d;
            sel_q    <= selection;
            d_o_q    <= d_o_d;
            wr_en_q  <= wr_en_d;
            fd_q     <= fd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign d_o        = d_o_q;
    assign wr_en      = wr_en_q;
    assign frame_done = fd_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_tbu_param.sv
// Directed bench for tbu_param (K=4, TB_LEN=16).
// With TBU_BEST_START_EN a second K=5 instance checks best-state restart.
module tb_tbu_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       selection;
    logic [7:0] d_in_0;
    logic [7:0] d_in_1;
    logic       d_o;
    logic       wr_en;
    logic       frame_done;
    logic [3:0] bit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tbu_param #(.K(4), .TB_LEN(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .selection  (selection),
        .d_in_0     (d_in_0),
        .d_in_1     (d_in_1),
`ifdef TBU_BEST_START_EN
        .start_state(3'd0),
`endif
        .d_o        (d_o),
        .wr_en      (wr_en),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt)
    );

`ifdef TBU_BEST_START_EN
    logic        en2;
    logic [15:0] d0_2;
    logic        do2, we2, fd2;
    logic [3:0]  bc2;

    tbu_param #(.K(5), .TB_LEN(16)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en2),
        .selection  (1'b0),
        .d_in_0     (d0_2),
        .d_in_1     (16'h0000),
        .start_state(4'hA),
        .d_o        (do2),
        .wr_en      (we2),
        .frame_done (fd2),
        .bit_cnt    (bc2)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        rst       = 1'b0;
        enable    = 1'b0;
        selection = 1'b0;
        d_in_0    = 8'h00;
        d_in_1    = 8'h00;
`ifdef TBU_BEST_START_EN
        en2  = 1'b0;
        d0_2 = 16'h0000;
`endif
        step();
        chk("rst_do", d_o, 0);
        chk("rst_wr", wr_en, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_ps", dut.pstate_q, 0);
        rst = 1'b1;
        step();

        // traceback-only phase on bank 0
        enable = 1'b1;
        d_in_0 = 8'h01;
        step();
        chk("tb0_ps4", dut.pstate_q, 4);
        chk("tb0_wr", wr_en, 0);
        chk("tb0_do", d_o, 0);
        d_in_0 = 8'h00;
        step();
        chk("tb0_ps2", dut.pstate_q, 2);
        chk("tb0_wr2", wr_en, 0);
        chk("tb0_do2", d_o, 0);

        // reload to 0, then output phase over a full frame
        enable = 1'b0;
        step();
        chk("dis_ps", dut.pstate_q, 0);
        chk("dis_cnt", bit_cnt, 0);
        enable    = 1'b1;
        selection = 1'b1;
        d_in_1    = 8'hFF;
        for (int i = 1; i <= 16; i++) begin
            step();
            st = (i == 1) ? 4 : (i == 2) ? 6 : 7;
            chk($sformatf("out_ps%0d", i), dut.pstate_q, st);
            chk($sformatf("out_wr%0d", i), wr_en, 1);
            chk($sformatf("out_do%0d", i), d_o, 1);
            chk($sformatf("out_cnt%0d", i), bit_cnt, i % 16);
            chk($sformatf("out_fd%0d", i), frame_done, (i == 16) ? 1 : 0);
        end

        // zero survivor bit from state 7
        d_in_1 = 8'h7F;
        step();
        chk("z_ps", dut.pstate_q, 3);
        chk("z_do", d_o, 0);
        chk("z_wr", wr_en, 1);
        chk("z_cnt", bit_cnt, 1);
        chk("z_fd", frame_done, 0);

        // 3 -> 5, then selection falls
        d_in_1 = 8'hFF;
        step();
        chk("f_ps5", dut.pstate_q, 5);
        chk("f_cnt2", bit_cnt, 2);
        selection = 1'b0;
        step();
        chk("fall_ps", dut.pstate_q, 0);
        chk("fall_cnt", bit_cnt, 0);
        chk("fall_wr", wr_en, 0);
        chk("fall_fd", frame_done, 0);

        // rising edge continues from 0: 0->4->2->5
        selection = 1'b1;
        d_in_1    = 8'hEF;
        step();
        chk("r_ps4", dut.pstate_q, 4);
        step();
        chk("r_ps2", dut.pstate_q, 2);
        chk("r_do0", d_o, 0);
        step();
        chk("r_ps5", dut.pstate_q, 5);
        chk("r_cnt3", bit_cnt, 3);

        // enable low together with selection fall
        enable    = 1'b0;
        selection = 1'b0;
        step();
        chk("both_ps", dut.pstate_q, 0);
        chk("both_cnt", bit_cnt, 0);
        chk("both_wr", wr_en, 0);

        // asynchronous reset mid-stream
        enable    = 1'b1;
        selection = 1'b1;
        d_in_1    = 8'hFF;
        step();
        step();
        chk("pre_ps", dut.pstate_q, 6);
        chk("pre_cnt", bit_cnt, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_do", d_o, 0);
        chk("arst_wr", wr_en, 0);
        chk("arst_fd", frame_done, 0);
        chk("arst_cnt", bit_cnt, 0);
        chk("arst_ps", dut.pstate_q, 0);
        enable    = 1'b0;
        selection = 1'b0;

`ifdef TBU_BEST_START_EN
        rst = 1'b1;
        en2 = 1'b0;
        step();
        chk("bs_ps10", dut2.pstate_q, 10);
        en2  = 1'b1;
        d0_2 = 16'h0400;
        step();
        chk("bs_ps13", dut2.pstate_q, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
